cla_5bit_checker: RTL and testbench
===================================

# cla_5bit_checker

Cycle-accurate response checker for the registered 5-bit carry-lookahead adder (`cla_5bit`). Sits on the output side of the adder: it observes each operand set as it is driven into the adder, computes the expected `{cout,sum}`, and compares it against the adder's result after a fixed pipeline latency. It keeps pass and error counts and raises a sticky error flag. It is synthesizable, so it serves both as a simulation scoreboard and as an on-chip built-in self-test.

## Interface
Parameters:
- `WIDTH`, 5: operand width; it must match the adder.
- `LATENCY`, 1: number of clk cycles from the operands being applied to `sum`/`cout` being valid; legal range 1..8.
- `CNT_W`, 16: width of the pass and error counters.

Ports:
- `clk`  in  1: single clock; everything is sampled on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: pulse; begins a check session.
- `stop`  in  1: pulse; ends a session after the pipeline drains.
- `in_valid`  in  1: the operands on `a_in`/`b_in`/`cin` this cycle form a vector to check.
- `a_in`, `b_in`  in  WIDTH: operands, tapped from the adder inputs.
- `cin`  in  1: carry-in, tapped from the adder input.
- `sum`  in  WIDTH: adder result.
- `cout`  in  1: adder carry-out.
- `busy`  out  1: high in RUN or DRAIN.
- `done`  out  1: high in DONE.
- `pass_cnt`  out  CNT_W: number of matching vectors.
- `err_cnt`  out  CNT_W: number of mismatching vectors.
- `err_flag`  out  1: sticky; set on the first mismatch.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE. Reset state is IDLE.
- IDLE:
  - `in_valid` is ignored.
  - `start` moves the FSM to RUN and clears the counters and `err_flag`.
- RUN:
  - Each `in_valid` pushes `{1, a_in+b_in+cin}` into the delay line.
  - The sum is computed at WIDTH+1 bits: bit WIDTH is the expected cout, and the low bits are the expected sum.
  - `stop` moves the FSM to DRAIN.
- DRAIN:
  - New `in_valid` is ignored, and a bubble is pushed instead.
  - After exactly LATENCY cycles the FSM moves to DONE.
- DONE:
  - Counters and flag hold.
  - `start` clears them and returns the FSM to RUN.
- Delay line:
  - A LATENCY-deep shift register of `{valid, exp_cout, exp_sum}`.
  - It shifts every cycle and pushes bubbles when nothing valid is entered.
- Compare:
  - When the tail entry is valid, compare `{cout,sum}` against the expected value.
  - On a match, `pass_cnt` increments; on a mismatch, `err_cnt` increments and `err_flag` is set.
- Counters saturate at all-ones and never wrap.
- `start` and `stop` in the same cycle:
  - In IDLE or DONE, `start` wins.
  - In RUN, `stop` wins.
  - In DRAIN, both are ignored.
- `start` while in RUN or DRAIN is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `pass_cnt`=0, `err_cnt`=0, `err_flag`=0. The delay line holds all bubbles.
- A vector with `in_valid` at edge N is compared against `sum`/`cout` sampled at edge N+LATENCY.
- The counter or flag update for that vector is visible after edge N+LATENCY, with zero added registered latency beyond the compare.
- Back-to-back `in_valid` is supported at one vector per cycle with no gaps.
- `stop` at edge S puts the FSM in DRAIN. `done` rises after edge S+LATENCY. The last vector accepted at edge S-1 is still checked.
- `rst` asserted mid-session takes effect at the next edge:
  - The FSM goes to IDLE.
  - Counters and flag clear.
  - The delay line flushes, and in-flight vectors are discarded without being counted.

## Configuration
- `CLA_CHK_CAPTURE_EN` defined:
  - Adds outputs `fail_a`, `fail_b` (WIDTH each), `fail_cin`, and `fail_got` (WIDTH+1).
  - These capture the operands and actual result of the first mismatch in a session.
  - They are loaded once, when `err_flag` rises, and hold until `start` or `rst`.
  - Their reset value is 0.
  - The delay line widens to carry the operands.
- `CLA_CHK_CAPTURE_EN` undefined: those ports and registers do not exist, and all other behaviour is identical.

## Test plan
- Reset, then `start`, then 5 vectors with LATENCY=1 against a correct adder: (1,1,0), (15,1,0), (21,10,0), (16,15,0), (31,31,0). Required: `pass_cnt`=5, `err_cnt`=0, `err_flag`=0, and `done` one cycle after `stop`.
- Correct adder but the `sum` bit 0 tap forced to 0 for vector (31,31,0), expected 62, actual {1,11110} still matches. Then force the vector (1,1,1) result to 3'b010. Required: `err_cnt`=1, `err_flag`=1, and with capture enabled `fail_a`=1, `fail_b`=1, `fail_cin`=1, `fail_got`=6'b000010.
- LATENCY=3, 10 back-to-back vectors, `stop` asserted on the cycle after the last vector. Required: all 10 counted, `busy` high for 3 DRAIN cycles, then `done`.
- `in_valid` pulsed in IDLE and in DONE. Required: counters unchanged.
- `rst` asserted with 2 vectors in flight (LATENCY=3). Required: next cycle shows all outputs at 0 and IDLE, and no late count increments.
- `pass_cnt` preloaded near saturation (CNT_W=4, 20 passing vectors). Required: `pass_cnt` holds at 15.

Source files
------------

// File: rtl/cla_5bit_checker.sv
// -----------------------------------------------------------------------------
// cla_5bit_checker
//
// Cycle-accurate response checker for the registered carry-lookahead adder.
// Each operand set presented with in_valid while a session runs is turned into
// an expected {cout,sum}. That value travels down a LATENCY-deep delay line and
// is compared against the adder result when it reaches the tail. Matches and
// mismatches are counted in saturating counters, and a sticky flag marks the
// first mismatch.
//
// Parameters:
//   WIDTH   - operand width, must match the adder
//   LATENCY - adder latency in clk cycles (legal range 1..8)
//   CNT_W   - width of pass_cnt / err_cnt
//
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   start, stop         - session control pulses
//   in_valid            - a_in/b_in/cin form a vector to check this cycle
//   a_in, b_in, cin     - operands tapped from the adder inputs
//   sum, cout           - adder result
//   busy                - session running or draining
//   done                - session finished; counters hold
//   pass_cnt, err_cnt   - saturating match / mismatch counts
//   err_flag            - sticky, set on the first mismatch
//
// Optional build macro CLA_CHK_CAPTURE_EN adds fail_a, fail_b, fail_cin and
// fail_got. They hold the operands and the actual result of the first
// mismatch in a session.
// -----------------------------------------------------------------------------
module cla_5bit_checker #(
  parameter int WIDTH   = 5,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag
`ifdef CLA_CHK_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH:0]   fail_got
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One delay-line stage. With capture enabled it also carries the operands so
  // the first failing vector can be reported.
  typedef struct packed {
    logic             vld;
`ifdef CLA_CHK_CAPTURE_EN
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
`endif
    logic [WIDTH:0]   exp;
  } entry_t;

  localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t          state;
  state_t          state_next;
  logic [DW-1:0]   drain_cnt;
  logic            drain_last;
  logic            push;
  logic            clear;
  entry_t          push_entry;
  entry_t          line_q [LATENCY];
  entry_t          tail;
  logic            hit;
  logic            miss;

  // The DRAIN state lasts exactly LATENCY cycles, so every accepted vector
  // reaches the tail before DONE.
  assign drain_last = (drain_cnt == DW'(LATENCY - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. In RUN only stop is examined, so stop wins over start.
  // In DRAIN both controls are ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start)      state_next = RUN;
      RUN:     if (stop)       state_next = DRAIN;
      DRAIN:   if (drain_last) state_next = DONE;
      DONE:    if (start)      state_next = RUN;
      default:                 state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and per-state strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    push  = 1'b0;
    clear = 1'b0;
    case (state)
      IDLE:  clear = start;
      RUN: begin
        busy = 1'b1;
        push = in_valid;
      end
      DRAIN: busy = 1'b1;
      DONE: begin
        done  = 1'b1;
        clear = start;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state != DRAIN)  drain_cnt <= '0;
    else if (!drain_last)       drain_cnt <= drain_cnt + DW'(1);
  end

  // ---------------------------------------------------------------------------
  // Expected result. The extra top bit of the WIDTH+1 sum is the expected cout.
  // ---------------------------------------------------------------------------
  always_comb begin
    push_entry     = '0;
    push_entry.vld = push;
    push_entry.exp = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, cin};
`ifdef CLA_CHK_CAPTURE_EN
    push_entry.a   = a_in;
    push_entry.b   = b_in;
    push_entry.c   = cin;
`endif
  end

  // ---------------------------------------------------------------------------
  // Delay line. It shifts every cycle, and a bubble enters whenever nothing is
  // pushed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this is a short flop chain, not a memory. Resetting it is what
      // discards in-flight vectors, so they are never counted after rst.
      for (int i = 0; i < LATENCY; i++) line_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage load its neighbour's
      // pre-edge value, so the loop order does not matter.
      line_q[0] <= push_entry;
      for (int i = 1; i < LATENCY; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign tail = line_q[LATENCY-1];
  assign hit  = tail.vld && ({cout, sum} == tail.exp);
  assign miss = tail.vld && ({cout, sum} != tail.exp);

  // ---------------------------------------------------------------------------
  // Saturating counters and sticky flag. clear only fires in IDLE/DONE, where
  // the line holds bubbles, so it never collides with a compare.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pass_cnt <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      if (hit && pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
      if (miss && err_cnt != '1) err_cnt  <= err_cnt + CNT_W'(1);
      if (miss)                  err_flag <= 1'b1;
    end
  end

`ifdef CLA_CHK_CAPTURE_EN
  // The capture registers load only on the rising edge of err_flag, so they
  // keep the first mismatch of the session.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fail_a   <= '0;
      fail_b   <= '0;
      fail_cin <= 1'b0;
      fail_got <= '0;
    end else if (miss && !err_flag) begin
      fail_a   <= tail.a;
      fail_b   <= tail.b;
      fail_cin <= tail.c;
      fail_got <= {cout, sum};
    end
  end
`endif

endmodule

// File: tb/tb_cla_5bit_checker.sv
// -----------------------------------------------------------------------------
// tb_cla_5bit_checker
//
// Two checkers share one stimulus stream. d1 uses LATENCY=1 and CNT_W=4, so it
// saturates. d3 uses LATENCY=3 and CNT_W=16. Each checker gets its own
// emulated registered adder. A per-vector fault override on that adder
// produces deliberate wrong results.
//
// The reference model is a list of vectors accepted in the current session,
// each tagged with the edge that sampled it and whether the adder answered
// correctly. After every edge, the expected counts are simply the number of
// vectors old enough (edge + LATENCY <= now), clipped to the counter maximum.
// -----------------------------------------------------------------------------
module tb_cla_5bit_checker;

  logic       clk = 1'b0;
  logic       rst, start, stop, in_valid, cin, fault_en;
  logic [4:0] a_in, b_in;
  logic [5:0] fault_val, adder_res, p1;
  logic [5:0] p3 [3];

  logic        d1_busy, d1_done, d1_flag, d3_busy, d3_done, d3_flag;
  logic [3:0]  d1_pass, d1_err;
  logic [15:0] d3_pass, d3_err;
`ifdef CLA_CHK_CAPTURE_EN
  logic [4:0]  d1_fa, d1_fb, d3_fa, d3_fb;
  logic        d1_fc, d3_fc;
  logic [5:0]  d1_fg, d3_fg;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Emulated registered adders, optionally returning a forced result.
  assign adder_res = fault_en ? fault_val
                              : ({1'b0, a_in} + {1'b0, b_in} + {5'b0, cin});
  always @(posedge clk) begin
    p1    <= adder_res;
    p3[0] <= adder_res;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  cla_5bit_checker #(.WIDTH(5), .LATENCY(1), .CNT_W(4)) d1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .cin(cin), .sum(p1[4:0]), .cout(p1[5]),
    .busy(d1_busy), .done(d1_done), .pass_cnt(d1_pass), .err_cnt(d1_err),
    .err_flag(d1_flag)
`ifdef CLA_CHK_CAPTURE_EN
    , .fail_a(d1_fa), .fail_b(d1_fb), .fail_cin(d1_fc), .fail_got(d1_fg)
`endif
  );

  cla_5bit_checker #(.WIDTH(5), .LATENCY(3), .CNT_W(16)) d3 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .cin(cin), .sum(p3[2][4:0]), .cout(p3[2][5]),
    .busy(d3_busy), .done(d3_done), .pass_cnt(d3_pass), .err_cnt(d3_err),
    .err_flag(d3_flag)
`ifdef CLA_CHK_CAPTURE_EN
    , .fail_a(d3_fa), .fail_b(d3_fb), .fail_cin(d3_fc), .fail_got(d3_fg)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int         edge_n;
    logic [4:0] a;
    logic [4:0] b;
    logic       c;
    logic [5:0] got;
    bit         ok;
  } vec_t;

  vec_t q[$];
  bit   sess_active = 1'b0;   // a session has been started since reset
  int   stop_edge   = 0;      // edge that sampled stop, 0 while running

  function automatic void model(input int lat, input int cmax,
                                output int p, output int e,
                                output int fa, output int fb,
                                output int fc, output int fg);
    bit found = 1'b0;
    p = 0; e = 0; fa = 0; fb = 0; fc = 0; fg = 0;
    foreach (q[i]) begin
      if (q[i].edge_n + lat <= cyc) begin
        if (q[i].ok) p++;
        else begin
          e++;
          if (!found) begin
            found = 1'b1;
            fa = int'(q[i].a); fb = int'(q[i].b);
            fc = int'(q[i].c); fg = int'(q[i].got);
          end
        end
      end
    end
    if (p > cmax) p = cmax;
    if (e > cmax) e = cmax;
  endfunction

  function automatic int exp_done(input int lat);
    return int'(sess_active && stop_edge != 0 && cyc >= stop_edge + lat);
  endfunction

  function automatic int exp_busy(input int lat);
    return int'(sess_active && exp_done(lat) == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    int p, e, fa, fb, fc, fg;
    model(1, 15, p, e, fa, fb, fc, fg);
    check("d1.busy", 32'(d1_busy), exp_busy(1));
    check("d1.done", 32'(d1_done), exp_done(1));
    check("d1.pass_cnt", 32'(d1_pass), p);
    check("d1.err_cnt", 32'(d1_err), e);
    check("d1.err_flag", 32'(d1_flag), int'(e > 0));
`ifdef CLA_CHK_CAPTURE_EN
    check("d1.fail_a", 32'(d1_fa), fa);
    check("d1.fail_b", 32'(d1_fb), fb);
    check("d1.fail_cin", 32'(d1_fc), fc);
    check("d1.fail_got", 32'(d1_fg), fg);
`endif
    model(3, 65535, p, e, fa, fb, fc, fg);
    check("d3.busy", 32'(d3_busy), exp_busy(3));
    check("d3.done", 32'(d3_done), exp_done(3));
    check("d3.pass_cnt", 32'(d3_pass), p);
    check("d3.err_cnt", 32'(d3_err), e);
    check("d3.err_flag", 32'(d3_flag), int'(e > 0));
`ifdef CLA_CHK_CAPTURE_EN
    check("d3.fail_a", 32'(d3_fa), fa);
    check("d3.fail_b", 32'(d3_fb), fb);
    check("d3.fail_cin", 32'(d3_fc), fc);
    check("d3.fail_got", 32'(d3_fg), fg);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // One stimulus cycle: drive inputs, tell the model what the next edge will
  // see, advance one clock and compare everything.
  task automatic cycle_in(input bit st, input bit sp, input bit v,
                          input logic [4:0] a, input logic [4:0] b,
                          input logic c, input bit fe, input logic [5:0] fv);
    bit   run;
    vec_t x;
    int   true_sum;
    start = st; stop = sp; in_valid = v;
    a_in = a; b_in = b; cin = c; fault_en = fe; fault_val = fv;
    run = sess_active && stop_edge == 0;
    if (run) begin
      if (v) begin
        true_sum = int'(a) + int'(b) + int'(c);
        x.edge_n = cyc + 1;
        x.a = a; x.b = b; x.c = c;
        x.got = fe ? fv : 6'(true_sum);
        x.ok  = (int'(x.got) == true_sum);
        q.push_back(x);
      end
      if (sp) stop_edge = cyc + 1;
    end else if (st) begin
      q.delete();
      sess_active = 1'b1;
      stop_edge   = 0;
    end
    tick();
    start = 1'b0; stop = 1'b0; in_valid = 1'b0; fault_en = 1'b0;
  endtask

  task automatic idle();
    cycle_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    q.delete();
    sess_active = 1'b0;
    stop_edge   = 0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // A randomized session: optional gaps, spurious start pulses while running,
  // random faults and ignored in_valid after stop.
  task automatic rand_session(input int n, input int fault_pct, input bit noisy);
    cycle_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0);
    for (int i = 0; i < n; i++) begin
      if (noisy && $urandom_range(3) == 0)
        cycle_in(1'b0, 1'b0, 1'b0, 5'($urandom), 5'($urandom), 1'($urandom),
                 1'b0, 6'd0);
      cycle_in(noisy && $urandom_range(15) == 0, 1'b0, 1'b1,
               5'($urandom), 5'($urandom), 1'($urandom),
               int'($urandom_range(99)) < fault_pct, 6'($urandom));
    end
    cycle_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0);
    repeat (5)
      cycle_in(1'b0, 1'b0, noisy && $urandom_range(1) == 0,
               5'($urandom), 5'($urandom), 1'($urandom), 1'b0, 6'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    a_in = '0; b_in = '0; cin = 1'b0; fault_en = 1'b0; fault_val = '0;

    // Reset state, then in_valid pulses while IDLE are ignored.
    do_reset(2);
    check("reset.d1_busy", 32'(d1_busy), 0);
    repeat (3) cycle_in(1'b0, 1'b0, 1'b1, 5'($urandom), 5'($urandom), 1'b0, 1'b0, 6'd0);

    // Session 1: five clean vectors.
    cycle_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0);
    cycle_in(1'b0, 1'b0, 1'b1, 5'd1,  5'd1,  1'b0, 1'b0, 6'd0);
    cycle_in(1'b0, 1'b0, 1'b1, 5'd15, 5'd1,  1'b0, 1'b0, 6'd0);
    cycle_in(1'b0, 1'b0, 1'b1, 5'd21, 5'd10, 1'b0, 1'b0, 6'd0);
    cycle_in(1'b0, 1'b0, 1'b1, 5'd16, 5'd15, 1'b0, 1'b0, 6'd0);
    cycle_in(1'b0, 1'b0, 1'b1, 5'd31, 5'd31, 1'b0, 1'b0, 6'd0);
    cycle_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0);
    check("s1.d1_busy_after_stop", 32'(d1_busy), 1);
    idle();
    check("s1.d1_done", 32'(d1_done), 1);
    check("s1.d1_pass", 32'(d1_pass), 5);
    check("s1.d1_err", 32'(d1_err), 0);
    check("s1.d1_flag", 32'(d1_flag), 0);
    idle(); idle();
    check("s1.d3_pass", 32'(d3_pass), 5);

    // in_valid pulses while DONE are ignored.
    repeat (3) cycle_in(1'b0, 1'b0, 1'b1, 5'($urandom), 5'($urandom), 1'b0, 1'b0, 6'd0);
    check("done_ivalid.d1_pass", 32'(d1_pass), 5);

    // Session 2: forced sum bit 0 still matches for 31+31; then a real mismatch.
    cycle_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0);
    cycle_in(1'b0, 1'b0, 1'b1, 5'd31, 5'd31, 1'b0, 1'b1, 6'b111110);
    cycle_in(1'b0, 1'b0, 1'b1, 5'd1,  5'd1,  1'b1, 1'b1, 6'b000010);
    cycle_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0);
    repeat (4) idle();
    check("s2.d1_err", 32'(d1_err), 1);
    check("s2.d1_flag", 32'(d1_flag), 1);
    check("s2.d3_pass", 32'(d3_pass), 1);
`ifdef CLA_CHK_CAPTURE_EN
    check("s2.d1_fail_a", 32'(d1_fa), 1);
    check("s2.d1_fail_b", 32'(d1_fb), 1);
    check("s2.d1_fail_cin", 32'(d1_fc), 1);
    check("s2.d1_fail_got", 32'(d1_fg), 2);
`endif

    // Session 3: ten back-to-back vectors, stop on the next cycle.
    cycle_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0);
    repeat (10)
      cycle_in(1'b0, 1'b0, 1'b1, 5'($urandom), 5'($urandom), 1'($urandom), 1'b0, 6'd0);
    cycle_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0);
    check("s3.drain1_busy", 32'(d3_busy), 1);
    idle();
    check("s3.drain2_busy", 32'(d3_busy), 1);
    idle();
    check("s3.drain3_busy", 32'(d3_busy), 1);
    idle();
    check("s3.d3_done", 32'(d3_done), 1);
    check("s3.d3_pass", 32'(d3_pass), 10);
    idle();

    // Saturation: 20 passing vectors on the 4-bit counter.
    rand_session(20, 0, 1'b0);
    check("sat.d1_pass", 32'(d1_pass), 15);
    check("sat.d3_pass", 32'(d3_pass), 20);

    // Randomized sessions with faults and control noise.
    repeat (4) rand_session(30, 15, 1'b1);

    // Reset with two vectors in flight on the LATENCY=3 checker.
    cycle_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0);
    cycle_in(1'b0, 1'b0, 1'b1, 5'd3, 5'd4, 1'b0, 1'b0, 6'd0);
    cycle_in(1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 6'd0);
    do_reset(1);
    check("rst.d3_busy", 32'(d3_busy), 0);
    check("rst.d3_pass", 32'(d3_pass), 0);
    check("rst.d3_err", 32'(d3_err), 0);
    repeat (5) idle();
    check("rst.d3_late_pass", 32'(d3_pass), 0);
    check("rst.d3_late_err", 32'(d3_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
